// File: rtl/data_memory_responder.sv
// MEM-stage data memory with a fixed multi-cycle access latency.
// Stalls the pipeline while an access is in flight and flags illegal requests.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_write_q, op_write_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q;
    logic            err_q, err_d;
    logic            mem_we, mem_re;
    logic            req, legal, in_range;

    logic [31:0]     mem_q [DEPTH_WORDS];

    assign req      = MemRead_i | MemWrite_i;
    assign in_range = ({2'b00, addr_i[31:2]} < 32'(DEPTH_WORDS));
    assign legal    = (MemRead_i ^ MemWrite_i) && (addr_i[1:0] == 2'b00) && in_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    stall_o    = 1'b1;
                    op_write_d = MemWrite_i;
                    idx_d      = addr_i[AW+1:2];
                    wdata_d    = data_i;
                    cnt_d      = CW'(LATENCY - 1);
                    state_d    = BUSY;
                end else if (req) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    mem_we  = op_write_q;
                    mem_re  = ~op_write_q;
                    state_d = DONE;
                end
            end
            // Requests seen here belong to the instruction just serviced.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            if (mem_re) data_q <= mem_q[idx_q];
        end
    end

    // Array is deliberately not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign data_o  = data_q;
    assign err_o   = err_q;
    assign ready_o = (state_q == DONE);

endmodule
